// File: rtl/gravity_sensor_ctrl.sv
// rtl/gravity_sensor_ctrl.sv - SPI poll controller for a two-axis gravity sensor
// GSENS_INIT_EN: send one POWER_CTL write frame before the first poll after reset.
module gravity_sensor_ctrl #(
  parameter int unsigned SCLK_DIV  = 4,
  parameter int unsigned CS_GAP    = 8,
  parameter int unsigned POLL_WAIT = 1000
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        enable,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic [11:0] x_value,
  output logic [11:0] y_value,
  output logic        sample_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_GAP,
    S_PUBLISH,
    S_WAIT
  } state_t;

  localparam logic [19:0] HALF_LAST  = 20'(SCLK_DIV - 1);
  localparam logic [19:0] BIT_LAST   = 20'(2 * SCLK_DIV - 1);
  localparam logic [19:0] GAP_LAST   = 20'(CS_GAP - 1);
  localparam logic [19:0] WAIT_LAST  = 20'(POLL_WAIT - 1);
  localparam logic [2:0]  FRAME_YL   = 3'd3;
  localparam logic [2:0]  FRAME_INIT = 3'd4;
  localparam logic [7:0]  CMD_READ   = 8'h0B;
  localparam logic [7:0]  CMD_WRITE  = 8'h0A;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [2:0]  frame_q, frame_d;
  logic [7:0]  rx_q, rx_d;
  logic [3:0]  xh_q, xh_d;
  logic [7:0]  xl_q, xl_d;
  logic [3:0]  yh_q, yh_d;
  logic [7:0]  yl_q, yl_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        sv_q, sv_d;
  logic        busy_q, busy_d;
  logic [23:0] tx_word;
  logic [2:0]  first_frame;

`ifdef GSENS_INIT_EN
  logic init_done_q, init_done_d;
  assign first_frame = init_done_q ? 3'd0 : FRAME_INIT;
`else
  assign first_frame = 3'd0;
`endif

  // Frames 0..3 are the X_H, X_L, Y_H, Y_L reads; frame 4 is the init write.
  always_comb begin
    tx_word = 24'h000000;
    case (frame_q)
      3'd0:    tx_word = {CMD_READ, 8'h0F, 8'h00};
      3'd1:    tx_word = {CMD_READ, 8'h0E, 8'h00};
      3'd2:    tx_word = {CMD_READ, 8'h11, 8'h00};
      3'd3:    tx_word = {CMD_READ, 8'h10, 8'h00};
      default: tx_word = {CMD_WRITE, 8'h2D, 8'h02};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    rx_d    = rx_q;
    xh_d    = xh_q;
    xl_d    = xl_q;
    yh_d    = yh_q;
    yl_d    = yl_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    x_d     = x_q;
    y_d     = y_q;
    sv_d    = 1'b0;
`ifdef GSENS_INIT_EN
    init_done_d = init_done_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_CS_SETUP;
          cnt_d   = 20'd0;
          frame_d = first_frame;
          cs_n_d  = 1'b0;
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = 20'd0;
          bit_d   = 5'd0;
          mosi_d  = tx_word[23];
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 20'd1;
        // miso is captured on the same edge that drives sclk high.
        if (cnt_q == HALF_LAST) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], miso};
        end
        if (cnt_q == BIT_LAST) begin
          cnt_d  = 20'd0;
          sclk_d = 1'b0;
          if (bit_q == 5'd23) begin
            state_d = S_CS_HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 5'd1;
            mosi_d = tx_word[5'd22 - bit_q];
          end
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_GAP;
          cnt_d   = 20'd0;
          cs_n_d  = 1'b1;
          case (frame_q)
            3'd0:    xh_d = rx_q[3:0];
            3'd1:    xl_d = rx_q;
            3'd2:    yh_d = rx_q[3:0];
            3'd3:    yl_d = rx_q;
            default: ;
          endcase
`ifdef GSENS_INIT_EN
          if (frame_q == FRAME_INIT) init_done_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 20'd0;
          if (!enable) begin
            state_d = S_IDLE;
            frame_d = 3'd0;
            xh_d = 4'd0;
            xl_d = 8'd0;
            yh_d = 4'd0;
            yl_d = 8'd0;
          end else if (frame_q == FRAME_YL) begin
            state_d = S_PUBLISH;
            x_d     = {xh_q, xl_q};
            y_d     = {yh_q, yl_q};
            sv_d    = 1'b1;
          end else begin
            state_d = S_CS_SETUP;
            cs_n_d  = 1'b0;
            frame_d = (frame_q == FRAME_INIT) ? 3'd0 : frame_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_PUBLISH: begin
        state_d = S_WAIT;
        cnt_d   = 20'd0;
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = 20'd0;
          frame_d = 3'd0;
          xh_d = 4'd0;
          xl_d = 8'd0;
          yh_d = 4'd0;
          yl_d = 8'd0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_CS_SETUP;
          cnt_d   = 20'd0;
          cs_n_d  = 1'b0;
          frame_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 20'd0;
      bit_q   <= 5'd0;
      frame_q <= 3'd0;
      rx_q    <= 8'd0;
      xh_q    <= 4'd0;
      xl_q    <= 8'd0;
      yh_q    <= 4'd0;
      yl_q    <= 8'd0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef GSENS_INIT_EN
      init_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      rx_q    <= rx_d;
      xh_q    <= xh_d;
      xl_q    <= xl_d;
      yh_q    <= yh_d;
      yl_q    <= yl_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
`ifdef GSENS_INIT_EN
      init_done_q <= init_done_d;
`endif
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign x_value      = x_q;
  assign y_value      = y_q;
  assign sample_valid = sv_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_gravity_sensor_ctrl.sv
// tb/tb_gravity_sensor_ctrl.sv - scoreboard bench with a behavioural SPI sensor model
module tb_gravity_sensor_ctrl;
  localparam int SD   = 4;
  localparam int GAPC = 3;
  localparam int PW   = 40;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        miso = 1'b0;
  logic        cs_n, sclk, mosi, sample_valid, busy;
  logic [11:0] x_value, y_value;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  gravity_sensor_ctrl #(.SCLK_DIV(SD), .CS_GAP(GAPC), .POLL_WAIT(PW)) dut (
    .clk1(clk1), .rst(rst), .enable(enable), .miso(miso),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .x_value(x_value), .y_value(y_value),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sensor register file and expected-behaviour model
  logic [7:0] reg_xh, reg_xl, reg_yh, reg_yl;
  int         seq_pos = 0;
`ifdef GSENS_INIT_EN
  bit         init_pending = 1'b1;
`else
  bit         init_pending = 1'b0;
`endif
  logic [3:0] served_mask = 4'd0;
  logic [7:0] sv_xh, sv_xl, sv_yh, sv_yl;
  logic [23:0] exp_q[$];

  function automatic logic [7:0] reg_read(input logic [7:0] a);
    case (a)
      8'h0F:   return reg_xh;
      8'h0E:   return reg_xl;
      8'h11:   return reg_yh;
      8'h10:   return reg_yl;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [23:0] exp_word();
    logic [7:0] a;
    if (init_pending) return 24'h0A2D02;
    case (seq_pos)
      0:       a = 8'h0F;
      1:       a = 8'h0E;
      2:       a = 8'h11;
      default: a = 8'h10;
    endcase
    return {8'h0B, a, 8'h00};
  endfunction

  task automatic model_frame_done(input logic [23:0] fw, input logic [7:0] data);
    if (init_pending) init_pending = 1'b0;
    else seq_pos = (seq_pos + 1) % 4;
    if (fw[23:16] == 8'h0B) begin
      case (fw[15:8])
        8'h0F: begin sv_xh = data; served_mask = 4'b0001; end
        8'h0E: begin sv_xl = data; served_mask |= 4'b0010; end
        8'h11: begin sv_yh = data; served_mask |= 4'b0100; end
        8'h10: begin
          sv_yl = data;
          if (served_mask == 4'b0111)
            exp_q.push_back({sv_xh[3:0], sv_xl, sv_yh[3:0], sv_yl});
          served_mask = 4'd0;
        end
        default: ;
      endcase
    end
  endtask

  // SPI bus monitor and sensor responder
  bit          prev_cs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, aborted = 1'b0;
  bit          gap_valid = 1'b0;
  int          rises = 0, cs_falls = 0, gap_expect = 0;
  int          t_cs_fall = 0, t_cs_rise = 0, t_rise = 0, t_fall = 0;
  logic [23:0] fw = 24'd0;
  logic [7:0]  cur_addr = 8'd0, cur_data = 8'd0;

  always @(negedge clk1) begin
    if (cs_n) check("sclk_low_while_cs_high", sclk, 0);
    if (rst || !enable) gap_valid = 1'b0;
    if (rst && in_frame) aborted = 1'b1;
    if (prev_cs && !cs_n) begin
      cs_falls++;
      if (gap_valid) check("cs_high_time", cyc - t_cs_rise, gap_expect);
      in_frame = 1'b1; aborted = 1'b0; rises = 0; fw = 24'd0;
      t_cs_fall = cyc;
      miso = 1'($urandom);
    end
    if (!cs_n && !prev_sclk && sclk && !aborted) begin
      rises++;
      fw = {fw[22:0], mosi};
      if (rises == 1) check("cs_fall_to_first_rise", cyc - t_cs_fall, 2 * SD);
      else check("bit_period", cyc - t_rise, 2 * SD);
      t_rise = cyc;
    end
    if (prev_sclk && !sclk && !aborted) begin
      check("sclk_high_width", cyc - t_rise, SD);
      t_fall = cyc;
      if (rises == 16) begin
        cur_addr = fw[7:0];
        cur_data = reg_read(cur_addr);
      end
      if (rises >= 16 && rises < 24) miso = cur_data[23 - rises];
      else miso = 1'($urandom);
    end
    if (!prev_cs && cs_n && in_frame) begin
      in_frame = 1'b0;
      t_cs_rise = cyc;
      gap_valid = 1'b0;
      if (!aborted) begin
        check("sclk_rises_per_frame", rises, 24);
        check("last_fall_to_cs_rise", cyc - t_fall, SD);
        check("frame_word", fw, exp_word());
        gap_expect = (fw[23:8] == 16'h0B10) ? GAPC + 1 + PW : GAPC;
        model_frame_done(fw, cur_data);
        gap_valid = 1'b1;
      end
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  // Output scoreboard
  logic [11:0] hold_x = 12'd0, hold_y = 12'd0;
  bit          rst_prev = 1'b0;

  always @(negedge clk1) begin
    logic [23:0] e;
    if (rst_prev) begin hold_x = 12'd0; hold_y = 12'd0; end
    if (sample_valid) begin
      if (exp_q.size() == 0) check("unexpected_sample_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        hold_x = e[23:12];
        hold_y = e[11:0];
        check("gap_to_publish", cyc - t_cs_rise, GAPC);
      end
    end
    check("x_value", x_value, hold_x);
    check("y_value", y_value, hold_y);
    rst_prev = rst;
  end

  task automatic wait_sample(input string name);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 4000) begin
      @(posedge clk1); #1;
      n++;
      if (sample_valid) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (cs_falls < target && n < 4000) begin
      @(posedge clk1); #1;
      n++;
    end
    check("wait_cs_fall", int'(cs_falls >= target), 1);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises < target && n < 400) begin
      @(posedge clk1); #1;
      n++;
    end
    check("wait_sclk_rise", int'(rises >= target), 1);
  endtask

  task automatic randomize_regs();
    reg_xh = 8'($urandom);
    reg_xl = 8'($urandom) | 8'h01;
    reg_yh = 8'($urandom);
    reg_yl = 8'($urandom);
  endtask

  initial begin
    int n;
    int base;
    reg_xh = 8'hF8; reg_xl = 8'h20; reg_yh = 8'h01; reg_yl = 8'h40;
    repeat (3) @(posedge clk1);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_x", x_value, 0);
    check("rst_y", y_value, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk1);

    #1 enable = 1'b1;
    check("cs_n_before_enable_seen", cs_n, 1);
    @(posedge clk1); #1;
    check("cs_n_after_enable_seen", cs_n, 0);
    check("busy_after_enable", busy, 1);

    wait_sample("wait_first_sample");
    check("first_x", x_value, 12'h820);
    check("first_y", y_value, 12'h140);
    randomize_regs();
    n = 0;
    while (cs_n && n < 4 * PW) begin
      @(posedge clk1); #1;
      n++;
    end
    check("sample_to_next_cs_fall", n, PW + 1);

    for (int i = 0; i < 3; i++) begin
      wait_sample("wait_random_sample");
      randomize_regs();
    end

    // Drop enable at bit 10 of the Y_H frame.
    base = cs_falls;
    wait_falls(base + 3);
    wait_rises(10);
    @(posedge clk1); #1 enable = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk1); #1;
      n++;
    end
    check("abort_reaches_idle", busy, 0);
    check("abort_frame_count", cs_falls, base + 3);
    check("abort_cs_n_high", cs_n, 1);
    repeat (20) @(posedge clk1);
    #1;
    check("abort_x_kept", x_value, hold_x);

    seq_pos = 0; served_mask = 4'd0;
    randomize_regs();
    enable = 1'b1;
    wait_sample("wait_after_abort");

    // Reset in the middle of the X_L frame.
    base = cs_falls;
    wait_falls(base + 2);
    wait_rises(5);
    @(posedge clk1); #1 rst = 1'b1;
    @(posedge clk1); #1;
    check("midframe_rst_cs_n", cs_n, 1);
    check("midframe_rst_sclk", sclk, 0);
    check("midframe_rst_x", x_value, 0);
    check("midframe_rst_y", y_value, 0);
    seq_pos = 0; served_mask = 4'd0;
`ifdef GSENS_INIT_EN
    init_pending = 1'b1;
`endif
    @(posedge clk1); #1;
    check("rst_beats_enable_busy", busy, 0);
    check("rst_beats_enable_cs_n", cs_n, 1);
    rst = 1'b0;
    randomize_regs();
    wait_sample("wait_after_rst");
    wait_sample("wait_second_after_rst");

    repeat (5) @(posedge clk1);
    #1 enable = 1'b0;
    @(posedge clk1); #1;
    check("wait_disable_busy", busy, 0);
    check("wait_disable_cs_n", cs_n, 1);
    repeat (PW + 20) @(posedge clk1);
    #1;
    check("idle_stays_cs_high", cs_n, 1);
    check("pending_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
